pwm_meas: RTL and testbench

PWM capture block: samples an asynchronous PWM input, measures its period and high time in `clk` cycles, and reports each completed measurement with a one-cycle valid strobe. It is the receive-side counterpart of the PWM generator. The block closes loopback tests on the DDS/PWM path and measures external PWM sources. A measurement taken from a generator running on the same clock with period P and high time H reports exactly P and H.

---
 rtl/pwm_meas_if.sv | 31 +++
 rtl/pwm_meas.sv | 177 +++++++++++++++++
 tb/tb_pwm_meas.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_meas_if.sv
// pwm_meas_if: control, input and result signals of the PWM capture block.
// The master side drives enable and the PWM input and receives the
// measurement results; the slave side is the capture block itself.
interface pwm_meas_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] h_time;
    logic             meas_vld;
    logic             timeout;

    modport master (
        output en,
        output pwm_in,
        input  period,
        input  h_time,
        input  meas_vld,
        input  timeout
    );

    modport slave (
        input  en,
        input  pwm_in,
        output period,
        output h_time,
        output meas_vld,
        output timeout
    );
endinterface

// File: rtl/pwm_meas.sv
// pwm_meas: PWM capture block. Synchronizes an asynchronous PWM input,
// measures period and high time in clk cycles and reports each completed
// measurement with a one-cycle meas_vld strobe. A one-cycle timeout strobe
// reports a period counter that saturated without its closing edge.
//
// Optional build macro PWM_MEAS_GLITCH_FILTER_EN: inserts a filter between
// the synchronizer and the edge detector so the level only changes after
// three consecutive identical synchronized samples (adds 2 cycles latency).
module pwm_meas #(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    pwm_meas_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             lvl;
    logic             rise, fall;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] hi_hold_q, hi_hold_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] h_time_q, h_time_d;
    logic             meas_vld_q, meas_vld_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] per_inc, hi_inc;

    // Two-flop synchronizer plus the history flop used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of its neighbours.
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.pwm_in;
            s2_q <= s1_q;
            s3_q <= lvl;
        end
    end

`ifdef PWM_MEAS_GLITCH_FILTER_EN
    logic h1_q, h2_q;

    // Two-deep history of the synchronized input for the glitch filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h1_q <= 1'b0;
            h2_q <= 1'b0;
        end else begin
            h1_q <= s2_q;
            h2_q <= h1_q;
        end
    end

    // Filtered level follows s2 only after three agreeing samples; s3 holds it otherwise.
    always_comb begin
        lvl = s3_q;
        if ((s2_q == h1_q) && (s2_q == h2_q)) begin
            lvl = s2_q;
        end
    end
`else
    // Unfiltered: every synchronized transition is passed to the edge detector.
    always_comb begin
        lvl = s2_q;
    end
`endif

    assign rise = lvl & ~s3_q;
    assign fall = ~lvl & s3_q;

    // Saturating increments so no counter ever wraps.
    assign per_inc = (per_cnt_q == CNT_MAX) ? CNT_MAX : per_cnt_q + CNT_ONE;
    assign hi_inc  = (hi_cnt_q == CNT_MAX) ? CNT_MAX : hi_cnt_q + CNT_ONE;

    // Next-state and datapath: enable low, then saturation, then edges.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        per_cnt_d  = per_cnt_q;
        hi_cnt_d   = hi_cnt_q;
        hi_hold_d  = hi_hold_q;
        period_d   = period_q;
        h_time_d   = h_time_q;
        meas_vld_d = 1'b0;
        timeout_d  = 1'b0;

        if (!bus.en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // First rise only opens a period; nothing to report yet.
                    if (rise) begin
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                        state_d   = HIGH;
                    end
                end
                HIGH: begin
                    if (per_cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        per_cnt_d = per_inc;
                        hi_cnt_d  = hi_inc;
                        if (fall) begin
                            // Capture the pre-increment count: it equals the high time.
                            hi_hold_d = hi_cnt_q;
                            state_d   = LOW;
                        end
                    end
                end
                LOW: begin
                    if (per_cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else if (rise) begin
                        period_d   = per_cnt_q;
                        h_time_d   = hi_hold_q;
                        meas_vld_d = 1'b1;
                        per_cnt_d  = CNT_ONE;
                        hi_cnt_d   = CNT_ONE;
                        state_d    = HIGH;
                    end else begin
                        per_cnt_d = per_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            per_cnt_q  <= '0;
            hi_cnt_q   <= '0;
            hi_hold_q  <= '0;
            period_q   <= '0;
            h_time_q   <= '0;
            meas_vld_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            hi_cnt_q   <= hi_cnt_d;
            hi_hold_q  <= hi_hold_d;
            period_q   <= period_d;
            h_time_q   <= h_time_d;
            meas_vld_q <= meas_vld_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.period   = period_q;
    assign bus.h_time   = h_time_q;
    assign bus.meas_vld = meas_vld_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_pwm_meas.sv
// tb_pwm_meas: directed bench for pwm_meas. Drives a same-clock PWM
// generator, logs every strobe with its cycle stamp and compares the log
// against hand-computed expectations.
module tb_pwm_meas;

    localparam int CNT_W = 16;
`ifdef PWM_MEAS_GLITCH_FILTER_EN
    localparam int LAT = 5;
    localparam int PS  = 6;
    localparam int HS  = 3;
`else
    localparam int LAT = 3;
    localparam int PS  = 2;
    localparam int HS  = 1;
`endif

    typedef struct {
        int cyc;
        int p;
        int h;
    } strobe_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    strobe_t vq[$];
    strobe_t eq[$];
    int      tq[$];

    pwm_meas_if #(.CNT_W(CNT_W)) bus ();

    pwm_meas #(.CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Strobe logger, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            strobe_t s;
            if (bus.meas_vld) begin
                s.cyc = cyc;
                s.p   = int'(bus.period);
                s.h   = int'(bus.h_time);
                vq.push_back(s);
            end
            if (bus.timeout) tq.push_back(cyc);
            if (bus.meas_vld || bus.timeout)
                check("vld_tmo_excl", {31'b0, bus.meas_vld & bus.timeout}, 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gen(input int p, input int h, input int n, output int e0);
        e0 = cyc;
        for (int i = 0; i < n; i++) begin
            bus.pwm_in = 1'b1;
            tick(h);
            bus.pwm_in = 1'b0;
            tick(p - h);
        end
    endtask

    task automatic add_exp(input int c, input int p, input int h);
        strobe_t s;
        s.cyc = c;
        s.p   = p;
        s.h   = h;
        eq.push_back(s);
    endtask

    task automatic compare(input string tag, input int exp_tmo);
        check({tag, "_count"}, vq.size(), eq.size());
        for (int i = 0; i < eq.size() && i < vq.size(); i++) begin
            check($sformatf("%s_cyc%0d", tag, i), vq[i].cyc, eq[i].cyc);
            check($sformatf("%s_per%0d", tag, i), vq[i].p, eq[i].p);
            check($sformatf("%s_hi%0d", tag, i), vq[i].h, eq[i].h);
        end
        check({tag, "_tmo_count"}, tq.size(), exp_tmo);
        vq.delete();
        eq.delete();
        tq.delete();
    endtask

    task automatic do_reset();
        bus.en     = 1'b1;
        bus.pwm_in = 1'b0;
        rst        = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        vq.delete();
        tq.delete();
    endtask

    task automatic run_basic(input string tag);
        int e0;
        gen(10, 3, 4, e0);
        tick(LAT + 2);
        for (int i = 1; i <= 3; i++) add_exp(e0 + 10 * i + LAT, 10, 3);
        compare(tag, 0);
    endtask

    initial begin
        int e0, e1, er, r1;
        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.pwm_in = 1'b0;
        tick(2);
        check("rst_period", {16'b0, bus.period}, 32'd0);
        check("rst_h_time", {16'b0, bus.h_time}, 32'd0);
        check("rst_meas_vld", {31'b0, bus.meas_vld}, 32'd0);
        check("rst_timeout", {31'b0, bus.timeout}, 32'd0);

        // P=10, H=3: no strobe on the first rise, then 10/3 every period.
        do_reset();
        run_basic("basic");

        // Minimum waveform, then switch to P=1000, H=999.
        do_reset();
        gen(PS, HS, 6, e0);
        gen(1000, 999, 3, e1);
        tick(LAT + 2);
        for (int i = 1; i <= 6; i++) add_exp(e0 + PS * i + LAT, PS, HS);
        add_exp(e1 + 1000 + LAT, 1000, 999);
        add_exp(e1 + 2000 + LAT, 1000, 999);
        compare("minsw", 0);

        // Input stuck high: one timeout, outputs hold, then fresh measurement.
        do_reset();
        gen(10, 3, 2, e0);
        er = cyc;
        bus.pwm_in = 1'b1;
        for (int i = 0; i < 70000 && tq.size() == 0; i++) tick(1);
        tick(3);
        if (tq.size() > 0) check("tmo_cyc", tq[0], er + LAT + 65535);
        check("tmo_hold_period", {16'b0, bus.period}, 32'd10);
        check("tmo_hold_h_time", {16'b0, bus.h_time}, 32'd3);
        add_exp(e0 + 10 + LAT, 10, 3);
        add_exp(er + LAT, 10, 3);
        compare("tmo", 1);
        bus.pwm_in = 1'b0;
        tick(5);
        gen(10, 4, 3, e1);
        tick(LAT + 2);
        add_exp(e1 + 10 + LAT, 10, 4);
        add_exp(e1 + 20 + LAT, 10, 4);
        compare("tmo_recover", 0);

        // Enable dropped mid-HIGH for 5 cycles.
        do_reset();
        gen(10, 3, 2, e0);
        er = cyc;
        bus.pwm_in = 1'b1;
        tick(5);
        bus.en = 1'b0;
        tick(5);
        bus.en = 1'b1;
        tick(2);
        bus.pwm_in = 1'b0;
        tick(8);
        gen(10, 3, 3, r1);
        tick(LAT + 2);
        add_exp(e0 + 10 + LAT, 10, 3);
        add_exp(er + LAT, 10, 3);
        add_exp(r1 + 10 + LAT, 10, 3);
        add_exp(r1 + 20 + LAT, 10, 3);
        compare("en", 0);

        // Asynchronous reset in the low phase, then the basic sequence again.
        do_reset();
        gen(10, 3, 2, e0);
        tick(3);
        check("pre_rst_period", {16'b0, bus.period}, 32'd10);
        #2 rst = 1'b1;
        #1;
        check("arst_period", {16'b0, bus.period}, 32'd0);
        check("arst_h_time", {16'b0, bus.h_time}, 32'd0);
        check("arst_meas_vld", {31'b0, bus.meas_vld}, 32'd0);
        check("arst_timeout", {31'b0, bus.timeout}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        vq.delete();
        tq.delete();
        run_basic("arst_recover");

        // One-cycle glitch inside the low phase of P=20, H=8.
        do_reset();
        gen(20, 8, 1, e0);
        er = cyc;
        bus.pwm_in = 1'b1;
        tick(8);
        bus.pwm_in = 1'b0;
        tick(6);
        bus.pwm_in = 1'b1;
        tick(1);
        bus.pwm_in = 1'b0;
        tick(5);
        gen(20, 8, 2, e1);
        tick(LAT + 2);
        add_exp(er + LAT, 20, 8);
`ifdef PWM_MEAS_GLITCH_FILTER_EN
        add_exp(e1 + LAT, 20, 8);
`else
        add_exp(er + 14 + LAT, 14, 8);
        add_exp(e1 + LAT, 6, 1);
`endif
        add_exp(e1 + 20 + LAT, 20, 8);
        compare("glitch", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
        $fatal(1, "watchdog");
    end

endmodule
